// File: rtl/d_mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and wait-counter width.
package d_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/d_mem_responder_bram.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module d_mem_responder_bram #(
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_ADDRESS_BITS = 12
) (
    input  logic                        clk,
    input  logic                        rd_en,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH/8-1:0]     byte_en,
    input  logic [MEM_ADDRESS_BITS-1:0] addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** MEM_ADDRESS_BITS;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // No reset on the array or the read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (byte_en[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/d_mem_responder.sv
// Memory-side responder for the core data-memory interface with programmable wait states.
// States: IDLE = accepting requests | BUSY = counting wait states | RESP = read data valid this cycle
module d_mem_responder
    import d_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDRESS_BITS     = 32,
    parameter int MEM_ADDRESS_BITS = 12,
    parameter int WAIT_CYCLES      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      d_mem_read,
    input  logic                      d_mem_write,
    input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
    input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
    input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
    output logic [DATA_WIDTH-1:0]     d_mem_data_out,
    output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
    output logic                      d_mem_valid,
    output logic                      d_mem_ready,
    output logic                      oob_error
);

    localparam cnt_t CNT_LOAD = cnt_t'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                      state, state_next;
    cnt_t                        cnt, cnt_next;
    logic                        pend_read;
    logic                        pipe_valid;
    logic                        data_sel;
    logic [DATA_WIDTH-1:0]       ram_q;
    logic [MEM_ADDRESS_BITS-1:0] index;
    logic                        in_range;
    logic                        accept;
    logic                        rd_accept;
    logic                        collision;

    assign index     = d_mem_address_in[MEM_ADDRESS_BITS+1:2];
    assign in_range  = (d_mem_address_in >> (MEM_ADDRESS_BITS + 2)) == '0;
    assign accept    = d_mem_ready && (d_mem_read || d_mem_write);
    assign collision = d_mem_read && d_mem_write;
    assign rd_accept = accept && d_mem_read && !d_mem_write;

    d_mem_responder_bram #(
        .DATA_WIDTH       (DATA_WIDTH),
        .MEM_ADDRESS_BITS (MEM_ADDRESS_BITS)
    ) u_bram (
        .clk     (clk),
        .rd_en   (rd_accept && in_range),
        .wr_en   (accept && d_mem_write && in_range),
        .byte_en (d_mem_byte_en),
        .addr    (index),
        .wdata   (d_mem_data_in),
        .rdata   (ram_q)
    );

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        d_mem_ready = 1'b1;
        case (state)
            ST_IDLE: begin
                if (accept && WAIT_CYCLES != 0) begin
                    state_next = ST_BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                d_mem_ready = 1'b0;
                if (cnt != '0) begin
                    cnt_next = cnt - cnt_t'(1);
                end else begin
                    state_next = pend_read ? ST_RESP : ST_IDLE;
                end
            end
            ST_RESP: begin
                d_mem_ready = 1'b0;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            pend_read         <= 1'b0;
            pipe_valid        <= 1'b0;
            data_sel          <= 1'b0;
            d_mem_address_out <= '0;
            oob_error         <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pipe_valid <= rd_accept;
            if (accept) begin
                pend_read <= rd_accept;
            end
            // Out-of-range reads answer with zero by deselecting the RAM output.
            if (rd_accept) begin
                d_mem_address_out <= d_mem_address_in;
                data_sel          <= in_range;
            end
            if (accept && (!in_range || collision)) begin
                oob_error <= 1'b1;
            end
        end
    end

    assign d_mem_data_out = data_sel ? ram_q : '0;
    assign d_mem_valid    = (WAIT_CYCLES == 0) ? pipe_valid : (state == ST_RESP);

endmodule
